// File: rtl/servo_btn_if.sv
// Button conditioner bundle: raw active-low buttons and enable toward the
// conditioner, debounced levels and single-cycle step strobes back out.
interface servo_btn_if;
  // Pulses are single-cycle strobes with no backpressure: the consumer must
  // act on every cycle where inc_pulse or dec_pulse is high. Levels are steady.
  logic enable;
  logic pb_inc_n;
  logic pb_dec_n;
  logic inc_pulse;
  logic dec_pulse;
  logic inc_level;
  logic dec_level;

  modport master (
    output enable, pb_inc_n, pb_dec_n,
    input  inc_pulse, dec_pulse, inc_level, dec_level
  );

  modport slave (
    input  enable, pb_inc_n, pb_dec_n,
    output inc_pulse, dec_pulse, inc_level, dec_level
  );
endinterface

// File: rtl/servo_btn_conditioner.sv
// Synchronise, debounce and pulse-convert the servo inc/dec push-buttons.
// Define SERVO_BTN_AUTOREPEAT_EN to add hold-to-repeat step pulses.
module servo_btn_conditioner #(
  parameter int DEBOUNCE_CYC     = 1000000,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000
) (
  input logic       clk,
  input logic       rst,
  servo_btn_if.slave btn
);

  if (DEBOUNCE_CYC < 2 || REPEAT_DELAY_CYC < 2 || REPEAT_RATE_CYC < 2) begin : g_param_check
    $error("servo_btn_conditioner: cycle parameters must be >= 2");
  end

  localparam int DB_W = $clog2(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  // Channel index 0 = increment, 1 = decrement; all *_n vectors are active-low.
  logic [1:0]      raw_n;
  logic [1:0]      sync1_n;
  logic [1:0]      sync2_n;
  logic [1:0]      stable_n;
  logic [1:0]      stable_nxt_n;
  logic [1:0]      flip;
  logic [1:0]      pressed_nxt;
  logic [1:0]      other_pressed_nxt;
  logic [1:0]      press_ok;
  logic [1:0]      pulse_q;
  logic [1:0]      pulse_nxt;
  logic [DB_W-1:0] db_cnt     [2];
  logic [DB_W-1:0] db_cnt_nxt [2];

  assign raw_n = {btn.pb_dec_n, btn.pb_inc_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_n <= 2'b11;
      sync2_n <= 2'b11;
    end else begin
      sync1_n <= raw_n;
      sync2_n <= sync1_n;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      flip[i]         = 1'b0;
      stable_nxt_n[i] = stable_n[i];
      db_cnt_nxt[i]   = '0;
      if (sync2_n[i] != stable_n[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          flip[i]         = 1'b1;
          stable_nxt_n[i] = sync2_n[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_n <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      stable_n <= stable_nxt_n;
      for (int i = 0; i < 2; i++) db_cnt[i] <= db_cnt_nxt[i];
    end
  end

  // Decisions use the post-edge debounced state so simultaneous presses
  // block each other and levels/pulses land on the same edge.
  assign pressed_nxt       = ~stable_nxt_n;
  assign other_pressed_nxt = {pressed_nxt[0], pressed_nxt[1]};
  assign press_ok          = flip & stable_n & ~other_pressed_nxt & {2{btn.enable}};

`ifdef SERVO_BTN_AUTOREPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int RP_W   = $clog2(RP_MAX);
  localparam logic [RP_W-1:0] RP_DELAY_LAST = RP_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RP_W-1:0] RP_RATE_LAST  = RP_W'(REPEAT_RATE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  rpt_state_t      rpt_state     [2];
  rpt_state_t      rpt_state_nxt [2];
  logic [RP_W-1:0] rpt_cnt       [2];
  logic [RP_W-1:0] rpt_cnt_nxt   [2];
  logic [1:0]      rpt_pulse;
  logic [1:0]      rpt_abort;

  assign rpt_abort = ~pressed_nxt | other_pressed_nxt | {2{~btn.enable}};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rpt_state[i] <= ST_IDLE;
        rpt_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rpt_state[i] <= rpt_state_nxt[i];
        rpt_cnt[i]   <= rpt_cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rpt_state_nxt[i] = rpt_state[i];
      rpt_cnt_nxt[i]   = '0;
      rpt_pulse[i]     = 1'b0;
      if (rpt_abort[i]) begin
        rpt_state_nxt[i] = ST_IDLE;
      end else begin
        case (rpt_state[i])
          ST_IDLE: begin
            if (press_ok[i]) rpt_state_nxt[i] = ST_DELAY;
          end
          ST_DELAY: begin
            if (rpt_cnt[i] == RP_DELAY_LAST) begin
              rpt_pulse[i]     = 1'b1;
              rpt_state_nxt[i] = ST_REPEAT;
            end else begin
              rpt_cnt_nxt[i] = rpt_cnt[i] + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt[i] == RP_RATE_LAST) begin
              rpt_pulse[i] = 1'b1;
            end else begin
              rpt_cnt_nxt[i] = rpt_cnt[i] + 1'b1;
            end
          end
          default: rpt_state_nxt[i] = ST_IDLE;
        endcase
      end
    end
  end

  assign pulse_nxt = press_ok | rpt_pulse;
`else
  assign pulse_nxt = press_ok;
`endif

  always_ff @(posedge clk) begin
    if (rst) pulse_q <= 2'b00;
    else     pulse_q <= pulse_nxt;
  end

  assign btn.inc_pulse = pulse_q[0];
  assign btn.dec_pulse = pulse_q[1];
  assign btn.inc_level = ~stable_n[0];
  assign btn.dec_level = ~stable_n[1];

endmodule

// File: tb/tb_servo_btn_conditioner.sv
// Directed bench for servo_btn_conditioner with short debounce/repeat timing.
// Repeat expectations follow SERVO_BTN_AUTOREPEAT_EN when it is defined.
module tb_servo_btn_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  servo_btn_if bif ();

  servo_btn_conditioner #(
    .DEBOUNCE_CYC    (4),
    .REPEAT_DELAY_CYC(10),
    .REPEAT_RATE_CYC (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(bif)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse events encoded as edge*2 + channel (0 = inc, 1 = dec).
  logic [15:0] exp_q  [$];
  logic [15:0] seen_q [$];

  int   edge_no;
  int   inc_rise, inc_fall, dec_rise, dec_fall;
  int   dec_hi_cnt;
  int   both_cnt = 0;
  logic inc_prev, dec_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic new_window();
    edge_no = 0;
    seen_q.delete();
    exp_q.delete();
    inc_rise = -1; inc_fall = -1; dec_rise = -1; dec_fall = -1;
    dec_hi_cnt = 0;
    inc_prev = bif.inc_level;
    dec_prev = bif.dec_level;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      edge_no++;
      if (bif.inc_pulse) seen_q.push_back(16'(edge_no * 2));
      if (bif.dec_pulse) seen_q.push_back(16'(edge_no * 2 + 1));
      if (bif.inc_pulse && bif.dec_pulse) both_cnt++;
      if (bif.dec_level) dec_hi_cnt++;
      if (bif.inc_level && !inc_prev && inc_rise < 0) inc_rise = edge_no;
      if (!bif.inc_level && inc_prev && inc_fall < 0) inc_fall = edge_no;
      if (bif.dec_level && !dec_prev && dec_rise < 0) dec_rise = edge_no;
      if (!bif.dec_level && dec_prev && dec_fall < 0) dec_fall = edge_no;
      inc_prev = bif.inc_level;
      dec_prev = bif.dec_level;
    end
  endtask

  task automatic cmp_q(input string tag);
    check({tag, "_count"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < seen_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), seen_q[i], exp_q[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bif.enable   = 1'b1;
    bif.pb_inc_n = 1'b0;
    bif.pb_dec_n = 1'b1;
    rst          = 1'b1;

    // Reset held with inc pressed
    repeat (5) @(posedge clk);
    #1;
    check("rst_inc_level", bif.inc_level, 0);
    check("rst_dec_level", bif.dec_level, 0);
    check("rst_inc_pulse", bif.inc_pulse, 0);
    check("rst_dec_pulse", bif.dec_pulse, 0);

    new_window();
    rst = 1'b0;
    run(5);
    check("rst_early_level", bif.inc_level, 0);
    run(5);
    exp_q.push_back(16'(6 * 2));
    cmp_q("rst_press");
    check("rst_rise_edge", inc_rise, 6);

    new_window();
    bif.pb_inc_n = 1'b1;
    run(10);
    cmp_q("rst_release");
    check("rst_fall_edge", inc_fall, 6);

    // Clean press and release
    new_window();
    bif.pb_inc_n = 1'b0;
    run(8);
    exp_q.push_back(16'(6 * 2));
    cmp_q("clean_press");
    check("clean_rise_edge", inc_rise, 6);
    check("clean_dec_quiet", dec_hi_cnt, 0);

    new_window();
    bif.pb_inc_n = 1'b1;
    run(10);
    cmp_q("clean_release");
    check("clean_fall_edge", inc_fall, 6);
    check("clean_dec_quiet2", dec_hi_cnt, 0);

    // Bounce on dec: 2-cycle toggles never satisfy debounce
    new_window();
    for (int s = 0; s < 7; s++) begin
      bif.pb_dec_n = (s % 2 == 0) ? 1'b0 : 1'b1;
      run(2);
    end
    bif.pb_dec_n = 1'b1;
    run(10);
    cmp_q("bounce");
    check("bounce_level", dec_hi_cnt, 0);

    // Long hold on dec, release after 40 edges
    new_window();
    bif.pb_dec_n = 1'b0;
    run(40);
    bif.pb_dec_n = 1'b1;
    run(10);
    exp_q.push_back(16'(6 * 2 + 1));
`ifdef SERVO_BTN_AUTOREPEAT_EN
    for (int e = 16; e <= 43; e += 3) exp_q.push_back(16'(e * 2 + 1));
`endif
    cmp_q("hold");
    check("hold_rise_edge", dec_rise, 6);
    check("hold_fall_edge", dec_fall, 46);

    // Both pressed together, then inc released, then dec re-pressed
    new_window();
    bif.pb_inc_n = 1'b0;
    bif.pb_dec_n = 1'b0;
    run(10);
    cmp_q("both_press");
    check("both_inc_level", bif.inc_level, 1);
    check("both_dec_level", bif.dec_level, 1);

    new_window();
    bif.pb_inc_n = 1'b1;
    run(10);
    cmp_q("both_inc_release");
    check("both_inc_fall", inc_fall, 6);
    check("both_dec_held", bif.dec_level, 1);

    new_window();
    bif.pb_dec_n = 1'b1;
    run(10);
    bif.pb_dec_n = 1'b0;
    run(10);
    exp_q.push_back(16'(16 * 2 + 1));
    cmp_q("dec_repress");
    bif.pb_dec_n = 1'b1;
    run(10);

    // Enable gating
    new_window();
    bif.enable   = 1'b0;
    bif.pb_inc_n = 1'b0;
    run(10);
    cmp_q("en_off_press");
    check("en_off_rise", inc_rise, 6);

    new_window();
    bif.enable = 1'b1;
    run(10);
    cmp_q("en_raise_held");
    check("en_raise_level", bif.inc_level, 1);

    new_window();
    bif.pb_inc_n = 1'b1;
    run(10);
    bif.pb_inc_n = 1'b0;
    run(10);
    exp_q.push_back(16'(16 * 2));
    cmp_q("en_repress");
    bif.pb_inc_n = 1'b1;
    run(10);

    check("pulse_mutex", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_btn_conditioner.md
Name: servo_btn_conditioner

Overview:
Upstream front end for the servo PWM stage. Conditions the two raw active-low push-buttons (increment/decrement):
- 2-FF synchronises each input, then debounces it with a counter.
- Emits single-cycle, mutually exclusive inc/dec step pulses, which feed the PWM stage's step inputs directly.
- Optional hold-to-repeat generates step pulses while a button is held.

Parameters:
- DEBOUNCE_CYC, 1000000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); must be ≥2.
- REPEAT_DELAY_CYC, 25000000: cycles from first pulse to first repeat pulse (500 ms); must be ≥2.
- REPEAT_RATE_CYC, 5000000: cycles between subsequent repeat pulses (100 ms); must be ≥2.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = pulses permitted; 0 = pulses blocked
- pb_inc_n  in  1  raw increment button, active-low, asynchronous
- pb_dec_n  in  1  raw decrement button, active-low, asynchronous
- inc_pulse  out  1  one-cycle increment step request
- dec_pulse  out  1  one-cycle decrement step request
- inc_level  out  1  debounced increment button state, 1 = pressed
- dec_level  out  1  debounced decrement button state, 1 = pressed

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - synchroniser flops ← 1 (released); debounce counters ← 0; stable states ← released.
  - inc_level = dec_level = 0; inc_pulse = dec_pulse = 0; repeat FSMs ← IDLE.
  - Reset mid-press discards all progress. A button held through reset must satisfy the full debounce again after rst falls.
- Synchroniser: 2 flops per channel; only the second flop's output is used downstream.
- Debounce, per channel:
  - If synced ≠ stable: counter increments.
  - If synced = stable: counter clears to 0.
  - On the edge where counter == DEBOUNCE_CYC-1 and synced still differs: stable flips and counter clears.
  - Counter width is $clog2(DEBOUNCE_CYC).
- Level outputs are registered inversions of the stable state: inc_level = ~stable_inc, dec_level = ~stable_dec.
- Latency: for a clean edge, the level output and first pulse assert on the (DEBOUNCE_CYC+2)th rising edge after the raw input changes. The first edge sampling the new level counts as edge 1.
- Pulse rules:
  - Each pulse is exactly 1 cycle and registered (no combinational path from inputs).
  - A channel's press pulse is issued only if enable=1 and the other channel's stable state is released.
  - Both channels becoming pressed on the same edge: no pulse on either.
  - Second button pressed while the first is held: no pulse for the second; the first channel's repeat stops.
  - inc_pulse and dec_pulse are never high together.
- Repeat FSM, per channel, states IDLE, DELAY, REPEAT; present only with AUTOREPEAT_EN:
  - IDLE → DELAY when the press pulse issues; repeat counter ← 0.
  - DELAY: after REPEAT_DELAY_CYC cycles → pulse, go to REPEAT, counter ← 0.
  - REPEAT: pulse every REPEAT_RATE_CYC cycles.
  - Any state → IDLE on any of: debounced release, other channel pressed, enable=0, rst. No pulse is emitted on that edge.
  - After an abort, a new pulse requires release and a re-press.
- enable=0: pulses forced 0 and FSMs held in IDLE. Debounce and levels keep tracking. Raising enable while a button is held does not produce a pulse; the button must be re-pressed.
- Repeat counter width: $clog2 of max(REPEAT_DELAY_CYC, REPEAT_RATE_CYC). The counter never wraps; it clears on every pulse and on every state change.

Optional Feature:
- Macro: SERVO_BTN_AUTOREPEAT_EN.
- Defined: repeat FSM and counter are present as described.
- Undefined:
  - Exactly one pulse per debounced press, regardless of hold time.
  - Repeat FSM, counter and the REPEAT_* parameters' logic are not generated; the parameters remain declared but are unused.
  - All other behaviour is identical.

Test Plan:
All scenarios use DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3, 20 ns clock.
- Reset: rst=1 for 5 cycles with pb_inc_n=0 → all outputs 0. Release rst with pb_inc_n held 0 → inc_pulse and inc_level assert on edge 6 after rst falls, not earlier.
- Clean press: pb_inc_n 1→0, held 8 cycles, no macro → inc_level=1 and single inc_pulse on edge 6. Release → inc_level=0 on edge 6 after release, no pulse. dec outputs stay 0 throughout.
- Bounce: pb_dec_n toggled every 2 cycles for 14 cycles, then held 1 → zero pulses, dec_level stays 0.
- Auto-repeat (macro defined): pb_dec_n held 0 for 40 cycles → dec_pulse on edges 6, 16, 19, 22, 25, …. No pulse after dec_level falls (edge 46 after press).
- Conflict: both buttons pressed on the same cycle → inc_level=dec_level=1, zero pulses. Release inc only → still no dec pulse until dec is re-pressed.
- Enable gating: enable=0, press inc for 10 cycles → inc_level=1, inc_pulse never asserts. Raise enable while held → no pulse. Release and re-press → pulse on edge 6.
